// File: rtl/adc_demod_pkg.sv
// Shared constants and types for the carrier demodulator: sample width,
// sqrt(3) scaling factor, alpha-max-beta-min coefficients and frame phase.
package adc_demod_pkg;
  localparam int SAMPLE_W     = 12;
  localparam int SQRT3_K      = 887;
  localparam int SQRT3_SH     = 9;
  localparam int ABM_BETA_NUM = 3;
  localparam int ABM_BETA_SH  = 3;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_e;
endpackage

// File: rtl/iq_mag_est.sv
// Two-stage magnitude estimator: |I|,|Q| -> max/min, then max + 3/8*min.
// Output holds its value between valid pulses.
module iq_mag_est
  import adc_demod_pkg::*;
#(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_v,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  output logic                out_v,
  output logic [W:0]          out_mag
);
  logic [W-1:0] w_ai;
  logic [W-1:0] w_aq;
  logic [W-1:0] r_mx;
  logic [W-1:0] r_mn;
  logic         r_v;

  // Inputs never reach the most negative code, so |x| fits in W unsigned bits.
  assign w_ai = in_i[W-1] ? $unsigned(-in_i) : $unsigned(in_i);
  assign w_aq = in_q[W-1] ? $unsigned(-in_q) : $unsigned(in_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v  <= 1'b0;
      r_mx <= '0;
      r_mn <= '0;
    end else begin
      r_v <= in_v;
      if (in_v) begin
        if (w_ai >= w_aq) begin
          r_mx <= w_ai;
          r_mn <= w_aq;
        end else begin
          r_mx <= w_aq;
          r_mn <= w_ai;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_v   <= 1'b0;
      out_mag <= '0;
    end else begin
      out_v <= r_v;
      if (r_v) begin
        out_mag <= (W+1)'({2'b00, r_mx} +
                   (({2'b00, r_mn} * (W+2)'(ABM_BETA_NUM)) >> ABM_BETA_SH));
      end
    end
  end
endmodule

// File: rtl/adc_carrier_demod.sv
// Carrier amplitude demodulator for fs/3 aliased carrier: per-frame I/Q
// projection, block accumulation, sqrt3 Q scaling and magnitude estimate.
// Optional macro DEMOD_IQ_OUT_EN exposes the I and scaled-Q block sums.
module adc_carrier_demod
  import adc_demod_pkg::*;
#(
  parameter  int LOG2_ACC = 4,
  localparam int MAG_W    = 15 + LOG2_ACC
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       restart,
  input  logic                       in_en,
  input  logic [SAMPLE_W-1:0]        in_data,
  output logic                       out_en,
  output logic [MAG_W-1:0]           out_mag
`ifdef DEMOD_IQ_OUT_EN
  ,
  output logic signed [13+LOG2_ACC:0] out_i,
  output logic signed [13+LOG2_ACC:0] out_q
`endif
);
  localparam int SUM_W  = 14 + LOG2_ACC;
  localparam int QSUM_W = 13 + LOG2_ACC;
  localparam int PROD_W = QSUM_W + 12;

  phase_e                r_ph;
  logic [SAMPLE_W-1:0]   r_s0;
  logic [SAMPLE_W-1:0]   r_s1;
  logic [LOG2_ACC-1:0]   r_fcnt;
  logic signed [SUM_W-1:0]  r_isum;
  logic signed [QSUM_W-1:0] r_qsum;

  logic signed [13:0]       w_i;
  logic signed [12:0]       w_q;
  logic signed [SUM_W-1:0]  w_isum_nxt;
  logic signed [QSUM_W-1:0] w_qsum_nxt;
  logic                     w_frame_end;
  logic                     w_block_end;

  logic                     r_b_v;
  logic signed [SUM_W-1:0]  r_b_i;
  logic signed [QSUM_W-1:0] r_b_q;
  logic signed [PROD_W-1:0] w_qprod;

  logic                     r_q_v;
  logic signed [SUM_W-1:0]  r_q_i;
  logic signed [SUM_W-1:0]  r_q_qs;

  // Projection onto the fs/3 carrier; coefficients sum to zero so mid-scale DC cancels.
  assign w_i = $signed({1'b0, r_s0, 1'b0}) - $signed({2'b00, r_s1}) - $signed({2'b00, in_data});
  assign w_q = $signed({1'b0, r_s1}) - $signed({1'b0, in_data});

  assign w_isum_nxt  = r_isum + {{LOG2_ACC{w_i[13]}}, w_i};
  assign w_qsum_nxt  = r_qsum + {{LOG2_ACC{w_q[12]}}, w_q};
  assign w_frame_end = in_en && !restart && (r_ph == PH2);
  assign w_block_end = w_frame_end && (r_fcnt == '1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ph   <= PH0;
      r_s0   <= '0;
      r_s1   <= '0;
      r_fcnt <= '0;
      r_isum <= '0;
      r_qsum <= '0;
    end else if (restart) begin
      r_ph   <= PH0;
      r_fcnt <= '0;
      r_isum <= '0;
      r_qsum <= '0;
    end else if (in_en) begin
      unique case (r_ph)
        PH0: begin
          r_s0 <= in_data;
          r_ph <= PH1;
        end
        PH1: begin
          r_s1 <= in_data;
          r_ph <= PH2;
        end
        PH2: begin
          r_ph <= PH0;
          if (w_block_end) begin
            r_fcnt <= '0;
            r_isum <= '0;
            r_qsum <= '0;
          end else begin
            r_fcnt <= r_fcnt + LOG2_ACC'(1);
            r_isum <= w_isum_nxt;
            r_qsum <= w_qsum_nxt;
          end
        end
        default: r_ph <= PH0;
      endcase
    end
  end

  // Block latch and sqrt3 scaling are not cleared by restart so in-flight results still emit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b_v <= 1'b0;
      r_b_i <= '0;
      r_b_q <= '0;
    end else begin
      r_b_v <= w_block_end;
      if (w_block_end) begin
        r_b_i <= w_isum_nxt;
        r_b_q <= w_qsum_nxt;
      end
    end
  end

  assign w_qprod = $signed({{12{r_b_q[QSUM_W-1]}}, r_b_q}) * $signed(PROD_W'(SQRT3_K));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q_v  <= 1'b0;
      r_q_i  <= '0;
      r_q_qs <= '0;
    end else begin
      r_q_v <= r_b_v;
      if (r_b_v) begin
        r_q_i  <= r_b_i;
        r_q_qs <= SUM_W'(w_qprod >>> SQRT3_SH);
      end
    end
  end

  iq_mag_est #(
    .W(SUM_W)
  ) u_mag (
    .clk     (clk),
    .rstn    (rstn),
    .in_v    (r_q_v),
    .in_i    (r_q_i),
    .in_q    (r_q_qs),
    .out_v   (out_en),
    .out_mag (out_mag)
  );

`ifdef DEMOD_IQ_OUT_EN
  logic                    r_d_v;
  logic signed [SUM_W-1:0] r_d_i;
  logic signed [SUM_W-1:0] r_d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d_v <= 1'b0;
      r_d_i <= '0;
      r_d_q <= '0;
      out_i <= '0;
      out_q <= '0;
    end else begin
      r_d_v <= r_q_v;
      if (r_q_v) begin
        r_d_i <= r_q_i;
        r_d_q <= r_q_qs;
      end
      if (r_d_v) begin
        out_i <= r_d_i;
        out_q <= r_d_q;
      end
    end
  end
`endif
endmodule

// File: tb/tb_adc_carrier_demod.sv
// Directed bench for adc_carrier_demod with LOG2_ACC=2 (4 frames per block).
module tb_adc_carrier_demod;
  localparam int L     = 2;
  localparam int MAG_W = 15 + L;

  logic             clk;
  logic             rstn;
  logic             restart;
  logic             in_en;
  logic [11:0]      in_data;
  logic             out_en;
  logic [MAG_W-1:0] out_mag;
`ifdef DEMOD_IQ_OUT_EN
  logic signed [13+L:0] out_i;
  logic signed [13+L:0] out_q;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [MAG_W-1:0] exp_q[$];
  logic [MAG_W-1:0] got_q[$];
  int               t_q[$];

  adc_carrier_demod #(
    .LOG2_ACC(L)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .restart (restart),
    .in_en   (in_en),
    .in_data (in_data),
    .out_en  (out_en),
    .out_mag (out_mag)
`ifdef DEMOD_IQ_OUT_EN
    ,
    .out_i   (out_i),
    .out_q   (out_q)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  always @(negedge clk) begin
    if (out_en) begin
      got_q.push_back(out_mag);
      t_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  // driver: call at a negedge; leaves the bus idle for gap-1 further cycles
  task automatic send(input logic [11:0] d, input int gap);
    in_en   = 1'b1;
    in_data = d;
    @(negedge clk);
    in_en   = 1'b0;
    in_data = 12'($urandom_range(0, 4095));
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frames(input logic [11:0] a, input logic [11:0] b,
                             input logic [11:0] c, input int frames, input int gap);
    for (int f = 0; f < frames; f++) begin
      send(a, gap);
      send(b, gap);
      send(c, gap);
    end
  endtask

  // scoreboard: wait for expected pulses, linger for spurious ones, compare
  task automatic check_block(input string tag);
    int n;
    int k;
    n = exp_q.size();
    k = 0;
    while (got_q.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (8) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), n);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_mag"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    t_q.delete();
  endtask

  initial begin
    int t0;
    int t1;
    rstn    = 1'b0;
    restart = 1'b0;
    in_en   = 1'b0;
    in_data = 12'd0;
    repeat (3) @(negedge clk);
    chk("reset_out_en", out_en, 0);
    chk("reset_out_mag", out_mag, 0);
    rstn = 1'b1;
    @(negedge clk);

    // DC input cancels
    send_frames(12'd2048, 12'd2048, 12'd2048, 4, 32);
    exp_q.push_back(0);
    check_block("dc");

    // pure I
    send_frames(12'd3048, 12'd1548, 12'd1548, 4, 32);
    exp_q.push_back(12000);
    check_block("pure_i");

    // pure Q
    send_frames(12'd2048, 12'd3048, 12'd1048, 4, 32);
    exp_q.push_back(13859);
    check_block("pure_q");

    // mixed I and Q
    send_frames(12'd3048, 12'd2548, 12'd548, 4, 32);
    exp_q.push_back(18359);
`ifdef DEMOD_IQ_OUT_EN
    repeat (4) @(negedge clk);
    chk("iq_out_i", out_i, 12000);
    chk("iq_out_q", out_q, 13859);
`endif
    check_block("mixed");

    // restart together with a sample after a partial block
    send_frames(12'd3048, 12'd2548, 12'd548, 1, 32);
    send(12'd100, 32);
    send(12'd4000, 32);
    in_en   = 1'b1;
    restart = 1'b1;
    in_data = 12'd3048;
    @(negedge clk);
    in_en   = 1'b0;
    restart = 1'b0;
    repeat (31) @(negedge clk);
    send_frames(12'd3048, 12'd1548, 12'd1548, 4, 32);
    exp_q.push_back(12000);
    check_block("restart");

    // back-to-back samples, two blocks
    send_frames(12'd3048, 12'd1548, 12'd1548, 8, 1);
    repeat (8) @(negedge clk);
    t0 = (t_q.size() >= 2) ? t_q[0] : 0;
    t1 = (t_q.size() >= 2) ? t_q[1] : 0;
    chk("b2b_spacing", 32'(t1 - t0), 12);
    exp_q.push_back(12000);
    exp_q.push_back(12000);
    check_block("b2b");

    // reset mid-block; stale partial must not contribute
    send_frames(12'd2048, 12'd3048, 12'd1048, 2, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_out_mag", out_mag, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_frames(12'd3048, 12'd1548, 12'd1548, 3, 1);
    send(12'd3048, 1);
    send(12'd1548, 1);
    check_block("midrst_partial");
    send(12'd1548, 1);
    exp_q.push_back(12000);
    check_block("midrst_full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
